// File: rtl/z_logger_pkg.sv
// Shared types and default widths for the z run logger.
package z_logger_pkg;
  localparam int CNT_W_DEF = 8;
  localparam int LEN_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load; priority clr > load > inc.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clr)
      count_nxt = '0;
    else if (load_en)
      count_nxt = load_val;
    else if (inc && (count != '1))
      count_nxt = count + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!rst)
      count <= '0;
    else
      count <= count_nxt;
  end
endmodule

// File: rtl/z_run_logger.sv
// Counts z rising edges and the longest z-high run, and hands out a frozen snapshot over valid/ready.
// Define Z_LOGGER_CLEAR_ON_READ_EN to restart the event/max window at every snapshot capture.
module z_run_logger
  import z_logger_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             z,
  input  logic             clr,
  input  logic             rd_req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] evt_count,
  output logic [LEN_W-1:0] max_len
);
  state_t           state;
  logic             z_q;
  logic             evt;
  logic             capture;
  logic             restart;
  logic [CNT_W-1:0] evt_cnt;
  logic [LEN_W-1:0] run_len;
  logic [LEN_W-1:0] run_nxt;
  logic [LEN_W-1:0] max_run;

  assign evt     = z && !z_q;
  assign capture = (state == IDLE) && rd_req;

`ifdef Z_LOGGER_CLEAR_ON_READ_EN
  assign restart = capture;
`else
  assign restart = 1'b0;
`endif

  sat_counter #(.WIDTH(CNT_W)) u_evt_cnt (
    .clock    (clock),
    .rst      (rst),
    .inc      (evt),
    .clr      (clr),
    .load_en  (restart),
    .load_val ({{(CNT_W-1){1'b0}}, evt}),
    .count    (evt_cnt)
  );

  sat_counter #(.WIDTH(LEN_W)) u_run_len (
    .clock    (clock),
    .rst      (rst),
    .inc      (z),
    .clr      (clr || !z),
    .load_en  (1'b0),
    .load_val ({LEN_W{1'b0}}),
    .count    (run_len)
  );

  // Look-ahead of the run counter so the ongoing run is folded into max_run on the same edge.
  always_comb begin
    run_nxt = run_len;
    if (clr || !z)
      run_nxt = '0;
    else if (run_len != '1)
      run_nxt = run_len + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      z_q     <= 1'b0;
      max_run <= '0;
    end else begin
      z_q <= z;
      if (clr)
        max_run <= '0;
      else if (restart)
        max_run <= run_nxt;
      else if (run_nxt > max_run)
        max_run <= run_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      evt_count <= '0;
      max_len   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            evt_count <= evt_cnt;
            max_len   <= max_run;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
